// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, start/data/stop decoding, one-entry output register.
// Optional 3-sample majority voting via UART_RX_MAJORITY_EN (default build: single sample).
module uart_rx #(
  parameter int BAUD_RATE     = 115200,
  parameter int CLK_FREQUENCY = 48000000,
  parameter int DATA_BITS     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_uart,
  input  logic                 rx_rdy,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_err
);

  localparam int CLKS_PER_BIT = (CLK_FREQUENCY + BAUD_RATE / 2) / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam int BW           = $clog2(DATA_BITS + 1);
`ifdef UART_RX_MAJORITY_EN
  // Majority decisions land one cycle after the nominal sample point.
  localparam int START_LAST   = HALF_BIT;
`else
  localparam int START_LAST   = HALF_BIT - 1;
`endif

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_ratio
      $error("uart_rx: CLKS_PER_BIT must be at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t               state_q, state_d;
  logic [1:0]           sync_q;
  logic                 line_prev_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 rx_valid_q, rx_valid_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_err_q, rx_err_d;
  logic                 line_s, bit_s, frame_ok_s, frame_bad_s;

  assign line_s = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], line_s};
    end
  end

  assign bit_s = maj3(hist_q[1], hist_q[0], line_s);
`else
  assign bit_s = line_s;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    frame_ok_s  = 1'b0;
    frame_bad_s = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        bit_cnt_d = '0;
        if (line_prev_q && !line_s) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (cnt_q == CW'(START_LAST)) begin
          cnt_d   = '0;
          state_d = bit_s ? IDLE : DATA;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          cnt_d                = '0;
          shift_d              = shift_q >> 1;
          shift_d[DATA_BITS-1] = bit_s;
          bit_cnt_d            = bit_cnt_q + 1'b1;
          state_d              = (bit_cnt_q == BW'(DATA_BITS - 1)) ? STOP : DATA;
        end else begin
          state_d = DATA;
        end
      end
      STOP: begin
        if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          cnt_d = '0;
          if (bit_s) begin
            frame_ok_s = 1'b1;
            state_d    = IDLE;
          end else begin
            frame_bad_s = 1'b1;
            state_d     = WAIT_IDLE;
          end
        end else begin
          state_d = STOP;
        end
      end
      WAIT_IDLE: begin
        // A held break stays here so it reports a single error.
        cnt_d   = '0;
        state_d = line_s ? IDLE : WAIT_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    rx_err_d   = 1'b0;
    if (frame_ok_s && (!rx_valid_q || rx_rdy)) begin
      rx_valid_d = 1'b1;
      rx_data_d  = shift_q;
    end else begin
      rx_valid_d = (rx_valid_q && rx_rdy) ? 1'b0 : rx_valid_q;
      rx_err_d   = frame_ok_s | frame_bad_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q      <= 2'b11;
      line_prev_q <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
      rx_err_q    <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], rx_uart};
      line_prev_q <= line_s;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      rx_err_q    <= rx_err_d;
    end
  end

  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign rx_err   = rx_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 10 clocks per bit; honours UART_RX_MAJORITY_EN.
module tb_uart_rx;

  localparam int CPB = 10;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_uart = 1'b1;
  logic       rx_rdy = 1'b1;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_err;

  always #5 clk = ~clk;

  uart_rx #(
    .BAUD_RATE(100000),
    .CLK_FREQUENCY(1000000),
    .DATA_BITS(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_uart(rx_uart),
    .rx_rdy(rx_rdy),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .rx_err(rx_err)
  );

  typedef struct {
    int         edge_no;
    bit         ok;
    logic [7:0] data;
  } ev_t;

  ev_t        ev_q[$];
  ev_t        m_ev;
  bit         m_have;
  int         edge_n = 0;
  int         checks = 0;
  int         errors = 0;
  int         valid_cycles = 0;
  int         err_cycles = 0;
  bit         exp_valid = 1'b0;
  logic [7:0] exp_data = 8'h00;
  bit         exp_err = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (edge %0d)", nm, act, req, edge_n);
    end
  endtask

  // Line level at a given clock offset from the start edge of a frame.
  function automatic logic wave(input int off, input logic [7:0] b, input logic sb, input int g);
    logic v;
    if (off < CPB) v = 1'b0;
    else if (off < 9 * CPB) v = b[(off - CPB) / CPB];
    else v = sb;
    if (off == g) v = ~v;
    return v;
  endfunction

  function automatic logic decide(input int off, input logic [7:0] b, input logic sb, input int g);
    logic a, m, c;
    a = wave(off - 1, b, sb, g);
    m = wave(off, b, sb, g);
    c = wave(off + 1, b, sb, g);
    return (MAJ != 0) ? ((a & m) | (a & c) | (m & c)) : m;
  endfunction

  // Reference: applies each scheduled frame outcome and the consumer handshake.
  initial begin
    forever begin
      @(posedge clk);
      edge_n++;
      if (reset) begin
        exp_valid = 1'b0;
        exp_data  = 8'h00;
        exp_err   = 1'b0;
        ev_q.delete();
      end else begin
        m_have = 1'b0;
        if (ev_q.size() > 0 && ev_q[0].edge_no == edge_n) begin
          m_ev   = ev_q.pop_front();
          m_have = 1'b1;
        end
        exp_err = 1'b0;
        if (m_have && m_ev.ok && (!exp_valid || rx_rdy)) begin
          exp_valid = 1'b1;
          exp_data  = m_ev.data;
        end else begin
          if (exp_valid && rx_rdy) exp_valid = 1'b0;
          if (m_have) exp_err = 1'b1;
        end
      end
      @(negedge clk);
      chk("rx_valid", {31'd0, rx_valid}, {31'd0, exp_valid});
      chk("rx_data", {24'd0, rx_data}, {24'd0, exp_data});
      chk("rx_err", {31'd0, rx_err}, {31'd0, exp_err});
      if (rx_valid === 1'b1) valid_cycles++;
      if (rx_err === 1'b1) err_cycles++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame; the outcome is decoded from mid-bit samples and scheduled.
  task automatic send_frame(input logic [7:0] b, input logic sb, input int g, input int tail_low);
    int         n0;
    ev_t        ev;
    logic [7:0] got;
    n0 = edge_n;
    if (decide(CPB / 2, b, sb, g) == 1'b0) begin
      got = 8'h00;
      for (int i = 0; i < 8; i++) got[i] = decide(CPB / 2 + CPB * (i + 1), b, sb, g);
      ev.edge_no = n0 + 2 + (CPB / 2 + 9 * CPB) + 1 + MAJ;
      ev.ok      = decide(CPB / 2 + 9 * CPB, b, sb, g);
      ev.data    = got;
      ev_q.push_back(ev);
    end
    for (int off = 0; off < 10 * CPB; off++) begin
      rx_uart = wave(off, b, sb, g);
      tick(1);
    end
    if (tail_low > 0) begin
      rx_uart = 1'b0;
      tick(tail_low);
    end
    rx_uart = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(4);
    chk("reset_valid", {31'd0, rx_valid}, 32'd0);
    chk("reset_data", {24'd0, rx_data}, 32'd0);
    chk("reset_err", {31'd0, rx_err}, 32'd0);
    reset = 1'b0;
    tick(10);

    // Single frame, consumer ready
    valid_cycles = 0; err_cycles = 0;
    send_frame(8'hA5, 1'b1, -1, 0);
    tick(20);
    chk("a5_valid_cycles", valid_cycles, 32'd1);
    chk("a5_err_cycles", err_cycles, 32'd0);
    chk("a5_data", {24'd0, rx_data}, 32'h0000_00A5);

    // Overrun: consumer not ready for two frames
    rx_rdy = 1'b0; valid_cycles = 0; err_cycles = 0;
    send_frame(8'h3C, 1'b1, -1, 0);
    tick(20);
    send_frame(8'h81, 1'b1, -1, 0);
    tick(20);
    chk("ovr_data", {24'd0, rx_data}, 32'h0000_003C);
    chk("ovr_valid", {31'd0, rx_valid}, 32'd1);
    chk("ovr_err_cycles", err_cycles, 32'd1);
    rx_rdy = 1'b1;
    tick(5);
    chk("ovr_drained", {31'd0, rx_valid}, 32'd0);

    // Framing error with a held break, then a good frame
    valid_cycles = 0; err_cycles = 0;
    send_frame(8'h55, 1'b0, -1, 30);
    tick(20);
    send_frame(8'h12, 1'b1, -1, 0);
    tick(20);
    chk("ferr_err_cycles", err_cycles, 32'd1);
    chk("ferr_valid_cycles", valid_cycles, 32'd1);
    chk("ferr_next_data", {24'd0, rx_data}, 32'h0000_0012);

    // Two-cycle glitch is a false start
    valid_cycles = 0; err_cycles = 0;
    rx_uart = 1'b0;
    tick(2);
    rx_uart = 1'b1;
    tick(30);
    chk("glitch_valid_cycles", valid_cycles, 32'd0);
    chk("glitch_err_cycles", err_cycles, 32'd0);
    send_frame(8'hC3, 1'b1, -1, 0);
    tick(20);
    chk("glitch_next_data", {24'd0, rx_data}, 32'h0000_00C3);

    // Reset during data bit 4 of 0xFF
    valid_cycles = 0; err_cycles = 0;
    rx_uart = 1'b0;
    tick(CPB);
    rx_uart = 1'b1;
    tick(4 * CPB + 5);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(10);
    chk("midrst_data", {24'd0, rx_data}, 32'd0);
    send_frame(8'h0F, 1'b1, -1, 0);
    tick(20);
    chk("midrst_valid_cycles", valid_cycles, 32'd1);
    chk("midrst_err_cycles", err_cycles, 32'd0);
    chk("midrst_data2", {24'd0, rx_data}, 32'h0000_000F);

    // One-cycle inverted glitch at the centre of data bit 2 of 0x00
    send_frame(8'h00, 1'b1, CPB / 2 + 3 * CPB, 0);
    tick(20);
    chk("maj_glitch_data", {24'd0, rx_data}, (MAJ != 0) ? 32'h0000_0000 : 32'h0000_0004);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
